// File: rtl/iterative_alu.sv
// Multi-cycle ALU for the execute stage: single-cycle ADD/SUB/AND/OR/SLT,
// plus shift-add unsigned multiply and restoring unsigned divide at one bit per clock.
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic              is_div_q, is_div_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  bop_q, bop_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  result_hi_q, result_hi_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  // Single-cycle datapath
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum, diff, slc_res;
  logic                    slc_ovf;

  always_comb begin
    a_s     = signed'(a);
    b_s     = signed'(b);
    sum     = a + b;
    diff    = a - b;
    slc_res = '0;
    slc_ovf = 1'b0;
    case (alucontrol)
      OP_ADD: begin
        slc_res = sum;
        slc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        slc_res = diff;
        slc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  slc_res = a & b;
      OP_OR:   slc_res = a | b;
      OP_SLT:  slc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: slc_res = '0;
    endcase
  end

  // One iteration step; hi/lo are shared between MUL (acc/multiplier) and DIV (rem/quotient)
  logic [WIDTH:0]   mul_sum, div_trial, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bop_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, bop_q};
    div_rem   = div_ge ? (div_trial - {1'b0, bop_q}) : div_trial;
    if (is_div_q) begin
      step_hi = div_rem[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    bop_d       = bop_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (alucontrol == OP_MULU || alucontrol == OP_DIVU) begin
            state_d  = S_RUN;
            is_div_d = (alucontrol == OP_DIVU);
            cnt_d    = CNTW'(WIDTH);
            hi_d     = '0;
            lo_d     = a;
            bop_d    = b;
          end else begin
            result_d    = slc_res;
            result_hi_d = '0;
            zero_d      = (slc_res == '0);
            ovf_d       = slc_ovf;
            dbz_d       = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNTW'(1);
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_q == CNTW'(1)) begin
          state_d     = S_IDLE;
          result_d    = step_lo;
          result_hi_d = step_hi;
          zero_d      = (step_lo == '0);
          ovf_d       = 1'b0;
          dbz_d       = is_div_q && (bop_q == '0);
          done_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      bop_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      bop_q       <= bop_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, res32, hi32;
  logic [7:0]  a8, b8, res8, hi8;
  logic        zero32, ovf32, dbz32, busy32, done32;
  logic        zero8, ovf8, dbz8, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic saw_done;

  always #5 clk = ~clk;

  iterative_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .alucontrol(op32), .a(a32), .b(b32),
    .result(res32), .result_hi(hi32), .zero(zero32), .overflow(ovf32),
    .div_by_zero(dbz32), .busy(busy32), .done(done32)
  );

  iterative_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .alucontrol(op8), .a(a8), .b(b8),
    .result(res8), .result_hi(hi8), .zero(zero8), .overflow(ovf8),
    .div_by_zero(dbz8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    start32 = 1'b1; op32 = op; a32 = av; b32 = bv;
    tick();
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    start8 = 1'b1; op8 = op; a8 = av; b8 = bv;
    tick();
    start8 = 1'b0;
  endtask

  // Counts busy cycles of dut32 until it drops, bounded
  task automatic wait32(output int n);
    n = 0;
    saw_done = 1'b0;
    while (busy32 && n < 200) begin
      if (done32) saw_done = 1'b1;
      n++;
      tick();
    end
    if (n >= 200) check("timeout32", 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
    op32 = 3'b000; op8 = 3'b000; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    check("rst_result", res32, 0);
    check("rst_hi", hi32, 0);
    check("rst_flags", {zero32, ovf32, dbz32, busy32, done32}, 5'b00000);
    reset = 1'b0;
    tick();

    // ADD overflow into sign bit
    issue32(3'b101, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_done", done32, 1);
    check("add_res", res32, 32'h8000_0000);
    check("add_flags", {zero32, ovf32, busy32}, 3'b010);
    tick();
    check("add_done_pulse", done32, 0);
    check("add_hold", res32, 32'h8000_0000);

    issue32(3'b001, 32'd10, 32'd10);
    check("sub_res", res32, 0);
    check("sub_flags", {zero32, ovf32}, 2'b10);

    issue32(3'b011, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg", res32, 1);
    issue32(3'b011, 32'd1, 32'hFFFF_FFFF);
    check("slt_swap", res32, 0);

    issue32(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_res", res32, 32'h00F0_1200);
    issue32(3'b100, 32'hF000_0001, 32'h0000_0F10);
    check("or_res", res32, 32'hF000_0F11);
    issue32(3'b010, 32'h1234_5678, 32'h9ABC_DEF0);
    check("rsv_res", {res32, zero32}, {32'h0, 1'b1});

    // MULU max*max
    issue32(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32(cyc);
    check("mul_busy_cycles", cyc, 32);
    check("mul_no_early_done", saw_done, 0);
    check("mul_done", done32, 1);
    check("mul_prod", {hi32, res32}, 64'hFFFF_FFFE_0000_0001);
    tick();
    check("mul_done_pulse", done32, 0);

    issue32(3'b111, 32'd100, 32'd7);
    wait32(cyc);
    check("div_busy_cycles", cyc, 32);
    check("div_qr", {hi32, res32}, {32'd2, 32'd14});
    check("div_dbz", dbz32, 0);

    issue32(3'b111, 32'd5, 32'd0);
    wait32(cyc);
    check("div0_qr", {hi32, res32}, {32'd5, 32'hFFFF_FFFF});
    check("div0_dbz", dbz32, 1);

    // start during RUN must be ignored, operands changing freely
    issue32(3'b111, 32'd100, 32'd7);
    repeat (4) tick();
    start32 = 1'b1; op32 = 3'b101; a32 = 32'd1; b32 = 32'd1;
    tick();
    start32 = 1'b0; a32 = 32'h55; b32 = 32'h3;
    wait32(cyc);
    check("busy_ign_cycles", cyc, 27);
    check("busy_ign_qr", {hi32, res32}, {32'd2, 32'd14});
    check("busy_ign_done", done32, 1);
    // back-to-back issue in the done cycle
    issue32(3'b101, 32'd1, 32'd1);
    check("b2b_done", done32, 1);
    check("b2b_res", {hi32, res32}, {32'd0, 32'd2});
    check("b2b_flags", {dbz32, ovf32, zero32}, 3'b000);

    // reset during RUN
    issue32(3'b110, 32'd3, 32'd5);
    repeat (9) tick();
    check("pre_rst_busy", busy32, 1);
    reset = 1'b1;
    tick();
    check("mrst_busy_done", {busy32, done32}, 2'b00);
    check("mrst_out", {hi32, res32}, 64'h0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      tick();
      if (done32 || busy32) saw_done = 1'b1;
    end
    check("mrst_no_done", saw_done, 0);

    // WIDTH=8 instance
    issue8(3'b110, 8'hFF, 8'hFF);
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      tick();
    end
    check("w8_busy_cycles", cyc, 8);
    check("w8_prod", {done8, hi8, res8}, {1'b1, 8'hFE, 8'h01});
    issue8(3'b001, 8'h80, 8'h01);
    check("w8_sub_ovf", {res8, ovf8, zero8}, {8'h7F, 1'b1, 1'b0});
    issue8(3'b111, 8'd200, 8'd10);
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      tick();
    end
    check("w8_div", {hi8, res8, zero8, dbz8}, {8'd0, 8'd20, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
